// File: rtl/instr_rom_fetch.sv
// Instruction fetch from a small hard-coded ROM with a programmable number of
// wait states, one outstanding request, flush/abort, and misalignment faults.
module instr_rom_fetch #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int PC_W   = 10,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_pc,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        dbg_state_o,
  output logic [2:0]        dbg_wait_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. req_ready and rsp_valid depend only on registered state.

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [2:0]  CNT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]  req_idx;
  logic              req_mis;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_err;
  logic              load_rsp;

  function automatic logic [DATA_W-1:0] rom_word(input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    case (32'(idx))
      0:       w = 32'h2001_0003;
      1:       w = 32'h2002_0009;
      2:       w = 32'h0022_1020;
      3:       w = 32'h0022_1824;
      4:       w = 32'h0022_2025;
      5:       w = 32'h0022_2827;
      6:       w = 32'h00A4_302A;
      default: w = 32'h0000_0000;
    endcase
    return DATA_W'(w);
  endfunction

  // Word index wraps modulo DEPTH, so upper PC bits beyond the ROM fold back.
  assign req_idx = IDX_W'(32'(req_pc[PC_W-1:2]) % 32'(DEPTH));
  assign req_mis = (req_pc[1:0] != 2'b00);

  // With zero wait states the ROM is read straight from the request.
  assign sel_idx = (state_q == S_IDLE) ? req_idx : idx_q;
  assign sel_err = (state_q == S_IDLE) ? req_mis : err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    load_rsp   = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (!flush && req_valid) begin
          idx_d = req_idx;
          err_d = req_mis;
          if (WAIT == 0) begin
            state_d  = S_RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    if (load_rsp) begin
      rsp_data_d = sel_err ? '0 : rom_word(sel_idx);
      rsp_err_d  = sel_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;
  assign dbg_wait_o  = cnt_q;

endmodule

// File: tb/tb_instr_rom_fetch.sv
// Directed bench for instr_rom_fetch: three instances with 0, 1 and 3 wait
// states, a vector table of fetches, and hand-written flush/reset sequences.
module tb_instr_rom_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [9:0]  req_pc    [3];
  logic        flush     [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_data  [3];
  logic        rsp_err   [3];
  logic [1:0]  dbg_state [3];
  logic [2:0]  dbg_wait  [3];

  int waits [3] = '{0, 1, 3};
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          d;
    logic [9:0]  pc;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  instr_rom_fetch #(.DATA_W(32), .DEPTH(64), .PC_W(10), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_pc(req_pc[0]), .flush(flush[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .dbg_state_o(dbg_state[0]), .dbg_wait_o(dbg_wait[0]));

  instr_rom_fetch #(.DATA_W(32), .DEPTH(64), .PC_W(10), .WAIT(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_pc(req_pc[1]), .flush(flush[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .dbg_state_o(dbg_state[1]), .dbg_wait_o(dbg_wait[1]));

  instr_rom_fetch #(.DATA_W(32), .DEPTH(64), .PC_W(10), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_pc(req_pc[2]), .flush(flush[2]), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]),
    .dbg_state_o(dbg_state[2]), .dbg_wait_o(dbg_wait[2]));

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data[d],       32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[d]),   32'd0);
    chk({tag, "_state"},     32'(dbg_state[d]), 32'd0);
    chk({tag, "_wait_cnt"},  32'(dbg_wait[d]),  32'd0);
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic fetch(input int d, input logic [9:0] pc, output logic [31:0] data,
                       output logic err, output int lat, output int seen_cyc);
    req_pc[d]    = pc;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    data     = rsp_data[d];
    err      = rsp_err[d];
    seen_cyc = cyc;
    @(posedge clk); #1;
    chk("valid_drops_after_delivery", 32'(rsp_valid[d]), 32'd0);
    chk("ready_after_delivery",       32'(req_ready[d]), 32'd1);
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic watch_no_valid(input int d, input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rsp_valid[d]) seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] data;
    logic        err;
    logic        seen;
    int          lat;
    int          seen_cyc;
    int          prev_d;
    int          prev_cyc;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_pc[i]    = '0;
      flush[i]     = 1'b0;
      rsp_ready[i] = 1'b1;
    end

    vecs.push_back('{d:1, pc:10'h000, data:32'h2001_0003, err:1'b0});
    vecs.push_back('{d:0, pc:10'h000, data:32'h2001_0003, err:1'b0});
    vecs.push_back('{d:0, pc:10'h004, data:32'h2002_0009, err:1'b0});
    vecs.push_back('{d:0, pc:10'h008, data:32'h0022_1020, err:1'b0});
    vecs.push_back('{d:0, pc:10'h00C, data:32'h0022_1824, err:1'b0});
    vecs.push_back('{d:0, pc:10'h010, data:32'h0022_2025, err:1'b0});
    vecs.push_back('{d:0, pc:10'h014, data:32'h0022_2827, err:1'b0});
    vecs.push_back('{d:0, pc:10'h018, data:32'h00A4_302A, err:1'b0});
    vecs.push_back('{d:1, pc:10'h006, data:32'h0000_0000, err:1'b1});
    vecs.push_back('{d:1, pc:10'h01C, data:32'h0000_0000, err:1'b0});
    vecs.push_back('{d:1, pc:10'h01A, data:32'h0000_0000, err:1'b1});
    vecs.push_back('{d:1, pc:10'h104, data:32'h2002_0009, err:1'b0});
    vecs.push_back('{d:1, pc:10'h100, data:32'h2001_0003, err:1'b0});
    vecs.push_back('{d:1, pc:10'h3FC, data:32'h0000_0000, err:1'b0});
    vecs.push_back('{d:2, pc:10'h010, data:32'h0022_2025, err:1'b0});
    vecs.push_back('{d:2, pc:10'h003, data:32'h0000_0000, err:1'b1});

    // Reset
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_reset_vals(i, "reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Vector table
    prev_d   = -1;
    prev_cyc = 0;
    foreach (vecs[i]) begin
      fetch(vecs[i].d, vecs[i].pc, data, err, lat, seen_cyc);
      chk($sformatf("vec%0d_data", i),    data,       vecs[i].data);
      chk($sformatf("vec%0d_err", i),     32'(err),   32'(vecs[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat),   32'(waits[vecs[i].d] + 1));
      if (vecs[i].d == 0 && prev_d == 0)
        chk($sformatf("vec%0d_spacing", i), 32'(seen_cyc - prev_cyc), 32'd2);
      prev_d   = vecs[i].d;
      prev_cyc = seen_cyc;
    end

    // Backpressure on the one-wait instance
    req_pc[1]    = 10'h00C;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_valid(1, lat);
    chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_hold_data",  rsp_data[1],       32'h0022_1824);
      chk("bp_req_ready",  32'(req_ready[1]), 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_still_valid", 32'(rsp_valid[1]), 32'd1);
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_delivered_valid", 32'(rsp_valid[1]), 32'd0);
    chk("bp_delivered_ready", 32'(req_ready[1]), 32'd1);

    // Flush one cycle after the handshake, three wait states
    req_pc[2]    = 10'h008;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    flush[2]     = 1'b1;
    @(posedge clk); #1;
    flush[2] = 1'b0;
    chk("flush_wait_state",    32'(dbg_state[2]), 32'd0);
    chk("flush_wait_ready",    32'(req_ready[2]), 32'd1);
    chk("flush_wait_cnt",      32'(dbg_wait[2]),  32'd0);
    watch_no_valid(2, 8, seen);
    chk("flush_wait_no_rsp",   32'(seen), 32'd0);
    fetch(2, 10'h018, data, err, lat, seen_cyc);
    chk("after_flush_data",    data,      32'h00A4_302A);
    chk("after_flush_latency", 32'(lat), 32'd4);

    // Flush and request together in IDLE: flush wins
    req_pc[0]    = 10'h004;
    req_valid[0] = 1'b1;
    flush[0]     = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    flush[0]     = 1'b0;
    chk("flush_idle_state", 32'(dbg_state[0]), 32'd0);
    chk("flush_idle_ready", 32'(req_ready[0]), 32'd1);
    watch_no_valid(0, 4, seen);
    chk("flush_idle_no_rsp", 32'(seen), 32'd0);

    // Flush together with rsp_ready in RESP: response dropped
    req_pc[1]    = 10'h004;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_valid(1, lat);
    chk("flush_resp_valid_before", 32'(rsp_valid[1]), 32'd1);
    flush[1]     = 1'b1;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    chk("flush_resp_valid_after", 32'(rsp_valid[1]), 32'd0);
    chk("flush_resp_state",       32'(dbg_state[1]), 32'd0);
    fetch(1, 10'h008, data, err, lat, seen_cyc);
    chk("after_flush_resp_data", data, 32'h0022_1020);

    // Reset pulsed mid-WAIT on the three-wait instance
    req_pc[2]    = 10'h014;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("pre_rst_state", 32'(dbg_state[2]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals(2, "async_rst");
    @(negedge clk) rst = 1'b0;
    req_pc[2]    = 10'h000;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("first_req_after_rst", 32'(dbg_state[2]), 32'd1);
    wait_valid(2, lat);
    chk("post_rst_latency", 32'(lat),     32'd4);
    chk("post_rst_data",    rsp_data[2],  32'h2001_0003);
    @(posedge clk); #1;
    watch_no_valid(2, 6, seen);
    chk("post_rst_no_stale", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
